// File: rtl/mem_arbiter.sv
// Arbitrates IF fetches against MEM loads/stores onto a byte-wide single-port RAM.
// Latency: N-byte read done in c(N+1) after grant, N-byte write done in c(N).
// Backpressure: requesters hold their request until the done pulse; no preemption.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_BYTES = 4,
    localparam int LW = $clog2(DATA_BYTES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    input  logic                      if_flush,
    output logic                      if_done,
    output logic [8*DATA_BYTES-1:0]   if_data,
    input  logic [1:0]                mem_rw,
    input  logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [LW-1:0]             mem_len,
    input  logic [8*DATA_BYTES-1:0]   mem_wdata,
    output logic                      mem_done,
    output logic [8*DATA_BYTES-1:0]   mem_rdata,
    output logic                      ram_rw,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [7:0]                ram_wdata,
    input  logic [7:0]                ram_rdata
);
    localparam int DW = 8 * DATA_BYTES;
    localparam int CW = LW + 1;

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t                state, state_nxt;
    logic                  fair;
    logic                  tgt_mem;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         n_q, i_q, r_q;
    logic [DW-1:0]         wdata_q, asm_q, asm_nxt;
    logic                  v1, v2;
    logic                  mem_req, grant_if, grant_mem, rd_last, abort;

    assign mem_req = (mem_rw == 2'b01) || (mem_rw == 2'b10);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        rd_last   = 1'b0;
        abort     = 1'b0;
        asm_nxt   = asm_q;
        asm_nxt[8*r_q[LW-1:0] +: 8] = ram_rdata;
        case (state)
            IDLE: begin
                grant_if  = if_req && (!mem_req || fair);
                grant_mem = mem_req && !grant_if;
                if (grant_if)       state_nxt = IF_RD;
                else if (grant_mem) state_nxt = (mem_rw == 2'b10) ? MEM_WR : MEM_RD;
            end
            IF_RD, MEM_RD: begin
                abort   = (state == IF_RD) && if_flush;
                rd_last = v2 && (r_q == n_q - 1'b1);
                if (abort)        state_nxt = IDLE;
                else if (rd_last) state_nxt = DONE;
            end
            MEM_WR:  if (i_q == n_q) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // v1/v2 track which cycles carry valid read data (RAM answers one cycle after the address)
    always_ff @(posedge clk) begin
        if (rst) begin
            fair      <= 1'b0;
            tgt_mem   <= 1'b0;
            addr_q    <= '0;
            n_q       <= '0;
            i_q       <= '0;
            r_q       <= '0;
            wdata_q   <= '0;
            asm_q     <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_data   <= '0;
            mem_rdata <= '0;
            ram_rw    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if || grant_mem) begin
                        addr_q   <= grant_if ? if_addr : mem_addr;
                        n_q      <= grant_if ? CW'(DATA_BYTES) : CW'(mem_len) + 1'b1;
                        wdata_q  <= mem_wdata;
                        tgt_mem  <= grant_mem;
                        asm_q    <= '0;
                        i_q      <= CW'(1);
                        r_q      <= '0;
                        v1       <= (state_nxt != MEM_WR);
                        v2       <= 1'b0;
                        ram_addr <= grant_if ? if_addr : mem_addr;
                        if (state_nxt == MEM_WR) begin
                            ram_rw    <= 1'b1;
                            ram_wdata <= mem_wdata[7:0];
                        end
                    end
                    if (grant_if) fair <= 1'b0;
                end
                IF_RD, MEM_RD: begin
                    if (abort) begin
                        v1 <= 1'b0;
                        v2 <= 1'b0;
                    end else begin
                        v1 <= (i_q < n_q);
                        v2 <= v1;
                        if (i_q < n_q) begin
                            ram_addr <= addr_q + ADDR_WIDTH'(i_q);
                            i_q      <= i_q + 1'b1;
                        end
                        if (v2) begin
                            asm_q <= asm_nxt;
                            r_q   <= r_q + 1'b1;
                        end
                        if (rd_last) begin
                            if (tgt_mem) begin
                                mem_rdata <= asm_nxt;
                                mem_done  <= 1'b1;
                            end else begin
                                if_data <= asm_nxt;
                                if_done <= 1'b1;
                            end
                        end
                    end
                end
                MEM_WR: begin
                    if (i_q < n_q) begin
                        ram_addr  <= addr_q + ADDR_WIDTH'(i_q);
                        ram_wdata <= wdata_q[8*i_q[LW-1:0] +: 8];
                        i_q       <= i_q + 1'b1;
                    end else begin
                        ram_rw    <= 1'b0;
                        ram_wdata <= '0;
                        mem_done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (tgt_mem && if_req) fair <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential, parametrised memory controller between the IF stage, the MEM stage and a byte-wide single-port RAM. It arbitrates instruction fetches against loads/stores and serialises each multi-byte access into one RAM byte per cycle. It assembles read bytes little-endian into a word and signals completion with a one-cycle done pulse. A fairness flag stops the MEM stage from starving fetch, and a flush input aborts a fetch that is in flight.

## Interface

Parameters:
- ADDR_WIDTH, 32, width of all byte addresses.
- DATA_BYTES, 4, word size in bytes; power of two, at least 2. LW = $clog2(DATA_BYTES).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_done or flush.
- if_addr  in  ADDR_WIDTH  fetch byte address.
- if_flush  in  1  aborts an in-flight fetch.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  8*DATA_BYTES  fetched word.
- mem_rw  in  2  01 load, 10 store, 00/11 idle; held until mem_done.
- mem_addr  in  ADDR_WIDTH  load/store byte address.
- mem_len  in  LW  byte count minus 1.
- mem_wdata  in  8*DATA_BYTES  store data; byte k = bits [8k+7:8k].
- mem_done  out  1  one-cycle pulse.
- mem_rdata  out  8*DATA_BYTES  load data, zero-extended above mem_len+1 bytes.
- ram_rw  out  1  0 read, 1 write.
- ram_addr  out  ADDR_WIDTH  RAM byte address.
- ram_wdata  out  8  RAM write byte.
- ram_rdata  in  8  RAM read byte; valid the cycle after its address is driven.

## Operation

- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE arbitration: the block accepts at most one request per edge.
  - If only one channel requests, it is granted.
  - If both request, MEM wins unless the fairness flag is set; then IF wins.
- Fairness flag:
  - Set when a MEM transaction completes while if_req is high.
  - Cleared when an IF transaction is granted.
- Grant latches the address, the byte count N, the write data and the target. N = DATA_BYTES for IF and mem_len+1 for MEM.
- The issue counter i runs 0..N-1. The receive counter r handles reads.
- Byte k address = latched_addr + k, modulo 2^ADDR_WIDTH (wrap-around is allowed).
- Reads: byte k is captured from ram_rdata into lane k of the assembly register.
  - Lanes at or above N are zero.
  - On completion the assembly register is copied to if_data or mem_rdata.
  - The other channel's output does not change.
- Writes: byte k drives ram_rw=1, ram_addr = addr+k and ram_wdata = mem_wdata byte k.
- DONE lasts exactly one cycle.
  - The matching done output is 1.
  - Requests are ignored during DONE.
  - DONE always goes to IDLE next.
  - Requesters must drop or change their request by the edge that ends DONE.
- if_flush during IF_RD: abort at that edge. The next state is IDLE, if_done is not pulsed and if_data is unchanged.
- if_flush in any other state has no effect. This includes the DONE cycle of an IF read, where if_data still updates.
- The block has no preemption: a MEM request arriving mid-fetch waits.
- While not writing: ram_rw=0, ram_wdata=0, and ram_addr holds the last issued address (0 after reset).

## Timing

- Reset, on the first edge with rst=1:
  - State IDLE, fairness flag 0, counters 0.
  - if_done=0, mem_done=0, if_data=0, mem_rdata=0.
  - ram_rw=0, ram_addr=0, ram_wdata=0.
- rst has priority over every other input, including in mid-transaction. The abandoned access produces no done pulse.
- Cycle numbering: grant edge E0; cycle c_j follows edge E_j.
- Read of N bytes:
  - Byte k address is driven in c_(k) for k=0..N-1; ram outputs are registered from state.
  - Byte k is captured at edge E_(k+2).
  - DONE occupies c_(N+1), with the data valid in that cycle.
  - A 4-byte fetch takes 5 cycles from grant to done.
- Write of N bytes:
  - Byte k is driven in c_(k).
  - DONE occupies c_(N).
- Back-to-back: the earliest next grant is the edge ending DONE+IDLE. The gap from DONE to the next issued address is 2 cycles.
- No combinational path from request inputs to ram_* or done outputs.

## Test plan

- Fetch only: if_addr=0x100, RAM bytes 0x13,0x05,0x50,0x00.
  - Required: ram_addr 0x100..0x103 in c0..c3, ram_rw=0 throughout.
  - Required: if_done in c5 with if_data=0x00500513, and mem_done stays 0.
- Store half: mem_rw=10, mem_addr=0x2002, mem_len=1, mem_wdata=0xAABBCCDD.
  - Required: ram_rw=1 with (0x2002,0xDD) in c0 and (0x2003,0xCC) in c1.
  - Required: mem_done in c2, then ram_rw=0.
- Load byte with wrap: mem_rw=01, mem_len=0, mem_addr=0xFFFFFFFF, RAM byte 0x80.
  - Required: mem_rdata=0x00000080 and mem_done in c2.
  - Load word at 0xFFFFFFFE: required addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- Simultaneous requests with both held:
  - Required: MEM is granted first.
  - After mem_done with if_req still high, both requesting again: required IF is granted.
  - After that IF completes: required MEM is granted.
- Flush: start fetch at 0x40, assert if_flush in c2.
  - Required: no if_done, if_data unchanged, IDLE next cycle.
  - Required: a pending MEM load is granted at the following edge.
- Reset mid-store: rst=1 in c1 of a 4-byte store.
  - Required: ram_rw=0 next cycle, no mem_done, all outputs 0.
  - Required: a new fetch after release completes normally.
